// File: rtl/multi_timer_periph_if.sv
// Bus-side interface of the multi-channel timer: single-cycle read/write strobes,
// byte address, write data, combinational read data and address-hit indication.
interface multi_timer_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output rd, output wr, output addr, output wdata,
                  input  rdata, input hit);
  modport slave  (input  rd, input  wr, input  addr, input  wdata,
                  output rdata, output hit);
endinterface

// File: rtl/multi_timer_periph.sv
// N_CH independent up-counting timers (TH reload / TL count / TCON / PRESC per channel)
// plus a global ISR, on the single-cycle MIPS data bus.
module multi_timer_periph #(
  parameter int          N_CH  = 4,
  parameter int          W     = 32,
  parameter int          PRE_W = 16,
  parameter logic [31:0] BASE  = 32'h40000040
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_timer_periph_if.slave   bus,
  output logic                  irqout,
  output logic [N_CH-1:0]       irq_vec
);

  logic [W-1:0]     th_q      [N_CH];
  logic [W-1:0]     th_d      [N_CH];
  logic [W-1:0]     tl_q      [N_CH];
  logic [W-1:0]     tl_d      [N_CH];
  logic [PRE_W-1:0] presc_q   [N_CH];
  logic [PRE_W-1:0] presc_d   [N_CH];
  logic [PRE_W-1:0] pre_cnt_q [N_CH];
  logic [PRE_W-1:0] pre_cnt_d [N_CH];
  logic [N_CH-1:0]  en_q, en_d, ie_q, ie_d, pend_q, pend_d, os_q, os_d;

  logic [31:0]      off_s;
  logic             ch_sel_s;
  logic             isr_sel_s;
  logic [2:0]       ch_idx_s;
  logic [1:0]       reg_s;
  logic [N_CH-1:0]  wr_th_s, wr_tl_s, wr_tcon_s, wr_presc_s;
  logic [N_CH-1:0]  tick_s, ovf_s, clr_s;
  logic [31:0]      rdata_s;

  // Window decode: channel registers are word-aligned within 16*N_CH bytes, ISR at +0x80.
  assign off_s     = bus.addr - BASE;
  assign ch_sel_s  = (off_s < 32'(16 * N_CH)) && (off_s[1:0] == 2'b00);
  assign isr_sel_s = (off_s == 32'h0000_0080);
  assign ch_idx_s  = off_s[6:4];
  assign reg_s     = off_s[3:2];
  assign bus.hit   = ch_sel_s | isr_sel_s;
  assign bus.rdata = rdata_s;

  // Per-channel write strobes, prescaler tick, overflow and W1C clear requests.
  always_comb begin
    wr_th_s    = '0;
    wr_tl_s    = '0;
    wr_tcon_s  = '0;
    wr_presc_s = '0;
    tick_s     = '0;
    ovf_s      = '0;
    clr_s      = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_th_s[i]    = bus.wr && ch_sel_s && (ch_idx_s == 3'(i)) && (reg_s == 2'd0);
      wr_tl_s[i]    = bus.wr && ch_sel_s && (ch_idx_s == 3'(i)) && (reg_s == 2'd1);
      wr_tcon_s[i]  = bus.wr && ch_sel_s && (ch_idx_s == 3'(i)) && (reg_s == 2'd2);
      wr_presc_s[i] = bus.wr && ch_sel_s && (ch_idx_s == 3'(i)) && (reg_s == 2'd3);
      tick_s[i]     = en_q[i] && (pre_cnt_q[i] == presc_q[i]);
      ovf_s[i]      = tick_s[i] && (tl_q[i] == {W{1'b1}});
      clr_s[i]      = (wr_tcon_s[i] && bus.wdata[2]) || (bus.wr && isr_sel_s && bus.wdata[i]);
    end
  end

  // Next-state: CPU writes beat counting, overflow set beats W1C clear, reload uses old TH.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      th_d[i]    = wr_th_s[i]    ? bus.wdata[W-1:0]     : th_q[i];
      presc_d[i] = wr_presc_s[i] ? bus.wdata[PRE_W-1:0] : presc_q[i];
      ie_d[i]    = wr_tcon_s[i]  ? bus.wdata[1]         : ie_q[i];
      os_d[i]    = wr_tcon_s[i]  ? bus.wdata[3]         : os_q[i];
      if (wr_tcon_s[i]) begin
        en_d[i] = bus.wdata[0];
      end else if (ovf_s[i] && os_q[i]) begin
        en_d[i] = 1'b0;
      end else begin
        en_d[i] = en_q[i];
      end
      if (wr_tl_s[i]) begin
        tl_d[i] = bus.wdata[W-1:0];
      end else if (ovf_s[i]) begin
        tl_d[i] = th_q[i];
      end else if (tick_s[i]) begin
        tl_d[i] = tl_q[i] + W'(1'b1);
      end else begin
        tl_d[i] = tl_q[i];
      end
      if (ovf_s[i]) begin
        pend_d[i] = 1'b1;
      end else if (clr_s[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
      // Zero when disabled or on a fresh 0->1 enable, so counting restarts cleanly.
      if (en_d[i] && en_q[i] && !tick_s[i]) begin
        pre_cnt_d[i] = pre_cnt_q[i] + PRE_W'(1'b1);
      end else begin
        pre_cnt_d[i] = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        th_q[i]      <= '0;
        tl_q[i]      <= '0;
        presc_q[i]   <= '0;
        pre_cnt_q[i] <= '0;
      end
      en_q   <= '0;
      ie_q   <= '0;
      pend_q <= '0;
      os_q   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        th_q[i]      <= th_d[i];
        tl_q[i]      <= tl_d[i];
        presc_q[i]   <= presc_d[i];
        pre_cnt_q[i] <= pre_cnt_d[i];
      end
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      os_q   <= os_d;
    end
  end

  // Read mux: zero unless a mapped register is read; narrow fields zero-extended.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.rd && ch_sel_s) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_idx_s == 3'(i)) begin
          case (reg_s)
            2'd0:    rdata_s = 32'(th_q[i]);
            2'd1:    rdata_s = 32'(tl_q[i]);
            2'd2:    rdata_s = {28'd0, os_q[i], pend_q[i], ie_q[i], en_q[i]};
            2'd3:    rdata_s = 32'(presc_q[i]);
            default: rdata_s = 32'h0000_0000;
          endcase
        end else begin
          rdata_s = rdata_s;
        end
      end
    end else if (bus.rd && isr_sel_s) begin
      rdata_s = 32'(pend_q);
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign irq_vec = pend_q & ie_q;
  assign irqout  = |irq_vec;

endmodule

// File: tb/tb_multi_timer_periph.sv
// Directed self-checking bench for multi_timer_periph (N_CH=4, W=32, PRE_W=16).
module tb_multi_timer_periph;
  localparam logic [31:0] BASE = 32'h40000040;

  logic       clk;
  logic       reset;
  logic       irqout;
  logic [3:0] irq_vec;
  int         checks;
  int         errors;

  multi_timer_periph_if bus ();

  multi_timer_periph #(.N_CH(4), .W(32), .PRE_W(16), .BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irqout  (irqout),
    .irq_vec (irq_vec)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.wr    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.rd   = 1'b1;
    #1;
    check(tag, bus.rdata, exp);
    bus.rd   = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    step(3);
    reset = 1'b1;
    step(1);

    // Reset values of every register
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd_chk($sformatf("reset_ch%0d_r%0d", c, r), BASE + 32'(16 * c + 4 * r), 32'h0);
      end
    end
    rd_chk("reset_isr", BASE + 32'h80, 32'h0);
    check("reset_irqout", {31'd0, irqout}, 32'h0);
    check("reset_irq_vec", {28'd0, irq_vec}, 32'h0);
    bus.addr = BASE + 32'h70;
    bus.rd   = 1'b1;
    #1;
    check("unmapped_hit", {31'd0, bus.hit}, 32'h0);
    check("unmapped_rdata", bus.rdata, 32'h0);
    bus.addr = BASE + 32'h80;
    #1;
    check("isr_hit", {31'd0, bus.hit}, 32'h1);
    bus.rd = 1'b0;
    #1;
    check("rdata_idle", bus.rdata, 32'h0);
    step(1);

    // Ch0 auto-reload with PRESC=0
    wr32(BASE + 32'h00, 32'hFFFF_FFFC);
    wr32(BASE + 32'h04, 32'hFFFF_FFFC);
    wr32(BASE + 32'h0C, 32'h0);
    wr32(BASE + 32'h08, 32'h3);           // edge E0
    rd_chk("ch0_tl_e0", BASE + 32'h04, 32'hFFFF_FFFC);
    step(3);                              // E3
    rd_chk("ch0_tl_e3", BASE + 32'h04, 32'hFFFF_FFFF);
    check("ch0_irq_e3", {31'd0, irqout}, 32'h0);
    step(1);                              // E4 overflow
    rd_chk("ch0_tl_e4", BASE + 32'h04, 32'hFFFF_FFFC);
    rd_chk("ch0_tcon_e4", BASE + 32'h08, 32'h7);
    check("ch0_irq_e4", {31'd0, irqout}, 32'h1);
    check("ch0_vec_e4", {28'd0, irq_vec}, 32'h1);
    step(3);                              // E7
    rd_chk("ch0_tl_e7", BASE + 32'h04, 32'hFFFF_FFFF);
    step(1);                              // E8 second reload
    rd_chk("ch0_tl_e8", BASE + 32'h04, 32'hFFFF_FFFC);
    step(3);                              // E11
    wr32(BASE + 32'h80, 32'h1);           // captured at E12, an overflow edge
    rd_chk("isr_set_wins", BASE + 32'h80, 32'h1);
    check("isr_set_wins_irq", {31'd0, irqout}, 32'h1);
    wr32(BASE + 32'h80, 32'h1);           // E13, no overflow
    rd_chk("isr_clear", BASE + 32'h80, 32'h0);
    check("isr_clear_irq", {31'd0, irqout}, 32'h0);
    wr32(BASE + 32'h08, 32'h0);           // E14: last tick then disabled
    rd_chk("ch0_tl_stop", BASE + 32'h04, 32'hFFFF_FFFE);
    step(2);
    rd_chk("ch0_tl_held", BASE + 32'h04, 32'hFFFF_FFFE);
    rd_chk("ch0_tcon_off", BASE + 32'h08, 32'h0);

    // Ch1 one-shot, PRESC=2, irq disabled
    wr32(BASE + 32'h14, 32'hFFFF_FFFE);
    wr32(BASE + 32'h1C, 32'h2);
    wr32(BASE + 32'h18, 32'h9);           // F0
    step(2);                              // F2
    rd_chk("ch1_tl_f2", BASE + 32'h14, 32'hFFFF_FFFE);
    step(1);                              // F3 first tick
    rd_chk("ch1_tl_f3", BASE + 32'h14, 32'hFFFF_FFFF);
    step(2);                              // F5
    bus.addr = BASE + 32'h18;
    bus.rd   = 1'b1;
    #1;
    check("ch1_tcon_f5", bus.rdata & 32'h7, 32'h1);
    bus.rd   = 1'b0;
    step(1);                              // F6 overflow, reload from TH1=0
    rd_chk("ch1_tl_f6", BASE + 32'h14, 32'h0);
    bus.addr = BASE + 32'h18;
    bus.rd   = 1'b1;
    #1;
    check("ch1_tcon_f6", bus.rdata & 32'h7, 32'h4);
    bus.rd   = 1'b0;
    check("ch1_irqout", {31'd0, irqout}, 32'h0);
    check("ch1_irq_vec", {28'd0, irq_vec}, 32'h0);
    step(3);
    rd_chk("ch1_tl_stopped", BASE + 32'h14, 32'h0);
    wr32(BASE + 32'h18, 32'h4);
    rd_chk("ch1_w1c", BASE + 32'h80, 32'h0);

    // Ch2: TL write beats tick, TH write during overflow
    wr32(BASE + 32'h20, 32'hFFFF_FFFD);
    wr32(BASE + 32'h24, 32'hFFFF_FFFD);
    wr32(BASE + 32'h2C, 32'h0);
    wr32(BASE + 32'h28, 32'h1);           // G0
    wr32(BASE + 32'h24, 32'h10);          // G1 tick
    rd_chk("ch2_tl_write_wins", BASE + 32'h24, 32'h10);
    step(1);                              // G2
    rd_chk("ch2_tl_after", BASE + 32'h24, 32'h11);
    wr32(BASE + 32'h24, 32'hFFFF_FFFE);   // G3
    step(1);                              // G4
    rd_chk("ch2_tl_g4", BASE + 32'h24, 32'hFFFF_FFFF);
    wr32(BASE + 32'h20, 32'h5);           // G5 overflow
    rd_chk("ch2_reload_old_th", BASE + 32'h24, 32'hFFFF_FFFD);
    rd_chk("ch2_th_new", BASE + 32'h20, 32'h5);
    rd_chk("ch2_isr", BASE + 32'h80, 32'h4);
    check("ch2_irq_masked", {31'd0, irqout}, 32'h0);
    step(3);                              // G8 overflow
    rd_chk("ch2_reload_new_th", BASE + 32'h24, 32'h5);
    wr32(BASE + 32'h28, 32'h4);           // G9
    rd_chk("ch2_tl_stop", BASE + 32'h24, 32'h6);
    rd_chk("ch2_cleared", BASE + 32'h80, 32'h0);

    // Ch3: asynchronous reset mid-count
    wr32(BASE + 32'h34, 32'h1234);
    wr32(BASE + 32'h38, 32'h3);           // H0
    step(2);                              // H2
    rd_chk("ch3_tl_run", BASE + 32'h34, 32'h1236);
    #2;
    reset = 1'b0;
    #1;
    rd_chk("ch3_tl_async", BASE + 32'h34, 32'h0);
    rd_chk("ch3_tcon_async", BASE + 32'h38, 32'h0);
    rd_chk("ch0_th_async", BASE + 32'h00, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(3);
    rd_chk("ch3_tl_post", BASE + 32'h34, 32'h0);
    rd_chk("ch3_tcon_post", BASE + 32'h38, 32'h0);
    check("post_irqout", {31'd0, irqout}, 32'h0);
    wr32(BASE + 32'h38, 32'h1);           // J0
    step(2);
    rd_chk("ch3_reenable", BASE + 32'h34, 32'h2);
    wr32(BASE + 32'h70, 32'hFFFF_FFFF);
    rd_chk("ch3_unmapped_wr", BASE + 32'h34, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
